decode_fwd_stage: RTL and testbench
===================================

Name: decode_fwd_stage

Overview:
- Parametrised decode-side operand stage for the 5-stage core.
- Selects each source operand from the register file or from one of NFWD downstream forwarding sources, in priority order.
- Detects load-use hazards from sources whose result is still pending, and stalls upstream on them.
- Holds the resolved operands in a valid/ready pipeline register feeding execute, with synchronous flush.

Parameters:
- XLEN, 64, data/operand width
- AW, 5, register address width
- PCW, 64, PC width
- NFWD, 3, number of forwarding sources; index 0 = youngest (E), then M, W, ... (highest priority first)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard held and incoming instruction
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage accepts upstream instruction this cycle
- in_pc  in  PCW  instruction PC
- in_ra1, in_ra2  in  AW each  source register addresses
- in_use1, in_use2  in  1 each  source operand actually read by instruction
- in_dst  in  AW  destination register
- in_rd1, in_rd2  in  XLEN each  register-file read data
- fwd_valid  in  NFWD  source i will write a register
- fwd_pending  in  NFWD  source i result not yet available (e.g. load in E)
- fwd_wa  in  NFWD*AW  source i destination, slice i = [i*AW +: AW]
- fwd_data  in  NFWD*XLEN  source i result
- out_valid  out  1  held instruction valid
- out_ready  in  1  execute accepts held instruction
- out_pc  out  PCW  registered PC
- out_dst  out  AW  registered destination
- out_src1, out_src2  out  XLEN each  registered resolved operands
- hazard  out  1  combinational load-use stall indicator

Behaviour:
- Operand resolution (combinational), per operand k:
  - Address 0 → value 0, never forwards, never hazards.
  - Otherwise scan i = 0..NFWD-1; first i with fwd_valid[i] && fwd_wa[i] == ra_k wins.
  - Winner not pending → use fwd_data[i].
  - Winner pending → operand hazard.
  - No winner → in_rd_k.
  - An older, non-pending match never overrides a younger pending one.
- hazard = in_valid && ((in_use1 && haz1) || (in_use2 && haz2)). An unused operand never stalls.
- in_ready = flush || (!hazard && (!out_valid || out_ready)).
- Capture: when in_valid && in_ready && !flush, register pc/dst/src1/src2 and set out_valid = 1 at the next edge.
- Drain: out_valid && out_ready with no capture → out_valid = 0.
- Hold: out_valid && !out_ready → all outputs stable; held operands are not re-resolved. Downstream is responsible for holding its forwarded values.
- Flush:
  - out_valid = 0 next edge.
  - Incoming instruction is consumed (in_ready = 1) and dropped.
  - Flush has priority over capture and hazard.
- Reset: out_valid = 0; out_pc, out_dst, out_src1, out_src2 = 0. Reset asserted mid-stall clears the held instruction; no state survives reset.
- Latency: 1 cycle from accepted input to out_valid. Throughput: 1/cycle when out_ready stays high.
- Simultaneous capture and drain in the same cycle: new instruction replaces the old one, out_valid stays 1.
- Payload registers update only on capture; otherwise unchanged (including when out_valid = 0).

Optional Feature:
- Macro: DECODE_FWD_PERF_EN
- Defined: adds outputs stall_cnt (32) and fwd_cnt (32).
  - stall_cnt increments each cycle hazard = 1 and flush = 0.
  - fwd_cnt increments by the number of operands (0-2) taking forwarded data on a capture.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Plain capture: ra1=3, ra2=4, rd1=0x11, rd2=0x22, no fwd_valid, out_ready=1 → next cycle out_valid=1, src1=0x11, src2=0x22.
- Priority: fwd_wa[0]=fwd_wa[2]=5, data0=0xAA, data2=0xCC, both valid, ra1=5 → src1=0xAA. Repeat with ra1=0 → src1=0.
- Load-use: fwd_pending[0]=1, fwd_wa[0]=7, ra2=7, in_use2=1 → hazard=1, in_ready=0, out_valid=0 after drain. Clear pending with data0=0x55 → captured src2=0x55. With in_use2=0 → no stall.
- Backpressure: out_ready=0 for 3 cycles after capture → in_ready=0, outputs unchanged. On release, next instruction is captured the same cycle the held one drains.
- Flush during hazard and during hold → in_ready=1, out_valid=0 next cycle, no capture.
- Reset mid-hold → out_valid=0 and all payload outputs 0 at the next edge. With DECODE_FWD_PERF_EN: 4 hazard cycles → stall_cnt=4; one capture with both operands forwarded → fwd_cnt=2.

Source files
------------

// File: rtl/decode_fwd_stage.sv
// Decode operand stage: picks each operand from the regfile or the youngest matching forward source, and stalls on pending load-use hits.
// Latency 1 cycle into a valid/ready register. Backpressure: in_ready drops on hazard or a held, unaccepted output; flush always accepts.
// Optional counters stall_cnt/fwd_cnt are built only when DECODE_FWD_PERF_EN is defined.
module decode_fwd_stage #(
  parameter int XLEN = 64,
  parameter int AW   = 5,
  parameter int PCW  = 64,
  parameter int NFWD = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PCW-1:0]       in_pc,
  input  logic [AW-1:0]        in_ra1,
  input  logic [AW-1:0]        in_ra2,
  input  logic                 in_use1,
  input  logic                 in_use2,
  input  logic [AW-1:0]        in_dst,
  input  logic [XLEN-1:0]      in_rd1,
  input  logic [XLEN-1:0]      in_rd2,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_pending,
  input  logic [NFWD*AW-1:0]   fwd_wa,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PCW-1:0]       out_pc,
  output logic [AW-1:0]        out_dst,
  output logic [XLEN-1:0]      out_src1,
  output logic [XLEN-1:0]      out_src2,
`ifdef DECODE_FWD_PERF_EN
  output logic                 hazard,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          fwd_cnt
`else
  output logic                 hazard
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] val;
    logic            haz;
    logic            fwd;
  } opnd_t;

  typedef struct packed {
    logic [PCW-1:0]  pc;
    logic [AW-1:0]   dst;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
  } hdr_t;

  // First match in index order wins, so a younger pending hit blocks older ready data.
  function automatic opnd_t resolve(
    input logic [AW-1:0]        ra,
    input logic [XLEN-1:0]      rd,
    input logic [NFWD-1:0]      fv,
    input logic [NFWD-1:0]      fp,
    input logic [NFWD*AW-1:0]   fwa,
    input logic [NFWD*XLEN-1:0] fd
  );
    opnd_t r;
    logic  hit;
    r.val = rd;
    r.haz = 1'b0;
    r.fwd = 1'b0;
    hit   = 1'b0;
    if (ra == '0) begin
      r.val = '0;
    end else begin
      for (int i = 0; i < NFWD; i++) begin
        if (!hit && fv[i] && (fwa[i*AW +: AW] == ra)) begin
          hit = 1'b1;
          if (fp[i]) begin
            r.haz = 1'b1;
          end else begin
            r.val = fd[i*XLEN +: XLEN];
            r.fwd = 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

  opnd_t op1, op2;
  hdr_t  hdr_q;
  logic  capture;

  always_comb begin
    op1 = resolve(in_ra1, in_rd1, fwd_valid, fwd_pending, fwd_wa, fwd_data);
    op2 = resolve(in_ra2, in_rd2, fwd_valid, fwd_pending, fwd_wa, fwd_data);
  end

  assign hazard   = in_valid && ((in_use1 && op1.haz) || (in_use2 && op2.haz));
  assign in_ready = flush || (!hazard && (!out_valid || out_ready));
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      hdr_q     <= '0;
    end else begin
      if (flush)
        out_valid <= 1'b0;
      else if (capture)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;

      if (capture) begin
        hdr_q.pc   <= in_pc;
        hdr_q.dst  <= in_dst;
        hdr_q.src1 <= op1.val;
        hdr_q.src2 <= op2.val;
      end
    end
  end

  assign out_pc   = hdr_q.pc;
  assign out_dst  = hdr_q.dst;
  assign out_src1 = hdr_q.src1;
  assign out_src2 = hdr_q.src2;

`ifdef DECODE_FWD_PERF_EN
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_sum = {1'b0, fwd_cnt} + {32'd0, op1.fwd} + {32'd0, op2.fwd};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (hazard && !flush && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (capture)
        fwd_cnt <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_decode_fwd_stage.sv
// Directed bench for decode_fwd_stage: vector table for operand resolution plus hand sequences for stall, hold, flush and reset.
module tb_decode_fwd_stage;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, in_ready;
  logic [63:0]  in_pc;
  logic [4:0]   in_ra1, in_ra2, in_dst;
  logic         in_use1, in_use2;
  logic [63:0]  in_rd1, in_rd2;
  logic [2:0]   fwd_valid, fwd_pending;
  logic [14:0]  fwd_wa;
  logic [191:0] fwd_data;
  logic         out_valid, out_ready;
  logic [63:0]  out_pc;
  logic [4:0]   out_dst;
  logic [63:0]  out_src1, out_src2;
  logic         hazard;
`ifdef DECODE_FWD_PERF_EN
  logic [31:0]  stall_cnt, fwd_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decode_fwd_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_ra1(in_ra1), .in_ra2(in_ra2), .in_use1(in_use1), .in_use2(in_use2),
    .in_dst(in_dst), .in_rd1(in_rd1), .in_rd2(in_rd2),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_wa(fwd_wa), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_dst(out_dst),
    .out_src1(out_src1), .out_src2(out_src2),
`ifdef DECODE_FWD_PERF_EN
    .hazard(hazard), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`else
    .hazard(hazard)
`endif
  );

  typedef struct {
    logic [4:0]   ra1, ra2;
    logic         use1, use2;
    logic [63:0]  rd1, rd2;
    logic [2:0]   fv, fp;
    logic [14:0]  fwa;
    logic [191:0] fd;
    logic         exp_haz, chk1, chk2;
    logic [63:0]  exp1, exp2;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [63:0] pc, input logic [4:0] ra1, input logic [4:0] ra2,
                           input logic [63:0] rd1, input logic [63:0] rd2, input logic [4:0] dst);
    in_valid = 1'b1; in_pc = pc; in_ra1 = ra1; in_ra2 = ra2;
    in_rd1 = rd1; in_rd2 = rd2; in_dst = dst; in_use1 = 1'b1; in_use2 = 1'b1;
    fwd_valid = '0; fwd_pending = '0; fwd_wa = '0; fwd_data = '0;
  endtask

  initial begin
    vecs[0] = '{5'd3, 5'd4, 1'b1, 1'b1, 64'h11, 64'h22, 3'b000, 3'b000, 15'd0, 192'd0,
                1'b0, 1'b1, 1'b1, 64'h11, 64'h22};
    vecs[1] = '{5'd5, 5'd4, 1'b1, 1'b1, 64'h11, 64'h22, 3'b101, 3'b000, {5'd5, 5'd0, 5'd5},
                {64'hCC, 64'h0, 64'hAA}, 1'b0, 1'b1, 1'b1, 64'hAA, 64'h22};
    vecs[2] = '{5'd0, 5'd4, 1'b1, 1'b1, 64'h11, 64'h22, 3'b101, 3'b000, {5'd5, 5'd0, 5'd0},
                {64'hCC, 64'h0, 64'hAA}, 1'b0, 1'b1, 1'b1, 64'h0, 64'h22};
    vecs[3] = '{5'd3, 5'd7, 1'b1, 1'b1, 64'h11, 64'h22, 3'b001, 3'b001, {5'd0, 5'd0, 5'd7},
                {64'h0, 64'h0, 64'h99}, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0};
    vecs[4] = '{5'd3, 5'd7, 1'b1, 1'b0, 64'h11, 64'h22, 3'b001, 3'b001, {5'd0, 5'd0, 5'd7},
                {64'h0, 64'h0, 64'h99}, 1'b0, 1'b1, 1'b0, 64'h11, 64'h0};
    vecs[5] = '{5'd3, 5'd7, 1'b1, 1'b1, 64'h11, 64'h22, 3'b001, 3'b000, {5'd0, 5'd0, 5'd7},
                {64'h0, 64'h0, 64'h55}, 1'b0, 1'b1, 1'b1, 64'h11, 64'h55};
    vecs[6] = '{5'd9, 5'd4, 1'b1, 1'b1, 64'h11, 64'h22, 3'b011, 3'b001, {5'd0, 5'd9, 5'd9},
                {64'h0, 64'hBB, 64'h0}, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0};
    vecs[7] = '{5'd6, 5'd6, 1'b1, 1'b1, 64'h11, 64'h22, 3'b110, 3'b000, {5'd6, 5'd6, 5'd0},
                {64'hCC, 64'hBB, 64'h0}, 1'b0, 1'b1, 1'b1, 64'hBB, 64'hBB};
    vecs[8] = '{5'd3, 5'd4, 1'b1, 1'b1, 64'h11, 64'h22, 3'b000, 3'b000, {5'd0, 5'd0, 5'd3},
                {64'h0, 64'h0, 64'hAA}, 1'b0, 1'b1, 1'b1, 64'h11, 64'h22};
    vecs[9] = '{5'd2, 5'd8, 1'b0, 1'b1, 64'h11, 64'h22, 3'b111, 3'b000, {5'd8, 5'd1, 5'd2},
                {64'hDD, 64'hBB, 64'hAA}, 1'b0, 1'b1, 1'b1, 64'hAA, 64'hDD};

    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    set_instr(64'h0, 5'd0, 5'd0, 64'h0, 64'h0, 5'd0);
    in_valid = 1'b0;
    tick(); tick();
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_pc", out_pc, 64'd0);
    chk("reset_out_src1", out_src1, 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 10; i++) begin
      set_instr(64'h1000 + 64'(i * 4), vecs[i].ra1, vecs[i].ra2, vecs[i].rd1, vecs[i].rd2, 5'(i + 1));
      in_use1 = vecs[i].use1; in_use2 = vecs[i].use2;
      fwd_valid = vecs[i].fv; fwd_pending = vecs[i].fp;
      fwd_wa = vecs[i].fwa; fwd_data = vecs[i].fd;
      #1;
      chk($sformatf("v%0d_hazard", i), {63'd0, hazard}, {63'd0, vecs[i].exp_haz});
      chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, !vecs[i].exp_haz});
      tick();
      chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, !vecs[i].exp_haz});
      if (!vecs[i].exp_haz) begin
        chk($sformatf("v%0d_out_pc", i), out_pc, 64'h1000 + 64'(i * 4));
        chk($sformatf("v%0d_out_dst", i), {59'd0, out_dst}, 64'(i + 1));
      end
      if (vecs[i].chk1) chk($sformatf("v%0d_src1", i), out_src1, vecs[i].exp1);
      if (vecs[i].chk2) chk($sformatf("v%0d_src2", i), out_src2, vecs[i].exp2);
    end

    // Backpressure: hold for 3 cycles, then drain and capture in the same cycle.
    set_instr(64'h2000, 5'd3, 5'd4, 64'h111, 64'h22, 5'd1);
    tick();
    out_ready = 1'b0;
    set_instr(64'h2004, 5'd3, 5'd4, 64'h222, 64'h22, 5'd2);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_in_ready", c), {63'd0, in_ready}, 64'd0);
      tick();
      chk($sformatf("hold%0d_out_valid", c), {63'd0, out_valid}, 64'd1);
      chk($sformatf("hold%0d_src1", c), out_src1, 64'h111);
      chk($sformatf("hold%0d_pc", c), out_pc, 64'h2000);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("release_out_valid", {63'd0, out_valid}, 64'd1);
    chk("release_src1", out_src1, 64'h222);
    chk("release_pc", out_pc, 64'h2004);
    in_valid = 1'b0;
    tick();
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
    chk("drain_pc_kept", out_pc, 64'h2004);

    // Flush while a load-use hazard is present.
    set_instr(64'h3000, 5'd3, 5'd7, 64'h11, 64'h22, 5'd3);
    fwd_valid = 3'b001; fwd_pending = 3'b001; fwd_wa = {5'd0, 5'd0, 5'd7};
    #1;
    chk("haz_pre_flush_in_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    #1;
    chk("flush_haz_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("flush_haz_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_haz_no_capture", out_pc, 64'h2004);
    flush = 1'b0;

    // Unissued instruction never stalls.
    in_valid = 1'b0;
    #1;
    chk("invalid_no_hazard", {63'd0, hazard}, 64'd0);

    // Flush while holding.
    set_instr(64'h4000, 5'd3, 5'd4, 64'h444, 64'h22, 5'd4);
    tick();
    out_ready = 1'b0;
    set_instr(64'h4004, 5'd3, 5'd4, 64'h448, 64'h22, 5'd5);
    flush = 1'b1;
    #1;
    chk("flush_hold_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("flush_hold_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_hold_pc", out_pc, 64'h4000);
    chk("flush_hold_src1", out_src1, 64'h444);
    flush = 1'b0;

    // Reset while holding clears everything.
    out_ready = 1'b1;
    set_instr(64'h5000, 5'd3, 5'd4, 64'h555, 64'h66, 5'd9);
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    tick();
    chk("prereset_out_valid", {63'd0, out_valid}, 64'd1);
    chk("prereset_src1", out_src1, 64'h555);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midreset_pc", out_pc, 64'd0);
    chk("midreset_dst", {59'd0, out_dst}, 64'd0);
    chk("midreset_src1", out_src1, 64'd0);
    chk("midreset_src2", out_src2, 64'd0);
    out_ready = 1'b1;

`ifdef DECODE_FWD_PERF_EN
    chk("perf_stall_reset", {32'd0, stall_cnt}, 64'd0);
    chk("perf_fwd_reset", {32'd0, fwd_cnt}, 64'd0);
    set_instr(64'h6000, 5'd3, 5'd7, 64'h11, 64'h22, 5'd6);
    fwd_valid = 3'b001; fwd_pending = 3'b001; fwd_wa = {5'd0, 5'd0, 5'd7};
    for (int c = 0; c < 4; c++) tick();
    in_valid = 1'b0;
    tick();
    chk("perf_stall_4", {32'd0, stall_cnt}, 64'd4);
    set_instr(64'h6004, 5'd3, 5'd4, 64'h11, 64'h22, 5'd7);
    fwd_valid = 3'b011; fwd_wa = {5'd0, 5'd4, 5'd3}; fwd_data = {64'h0, 64'hB4, 64'hA3};
    tick();
    in_valid = 1'b0;
    chk("perf_fwd_2", {32'd0, fwd_cnt}, 64'd2);
    chk("perf_fwd_src1", out_src1, 64'hA3);
    chk("perf_fwd_src2", out_src2, 64'hB4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
